// File: rtl/serial_parity_rx_pkg.sv
// Shared types for the serial parity receiver: FSM state encoding and the
// width of the optional error counter (SERIAL_PARITY_RX_ERR_CNT_EN).
`timescale 1ns/1ps
package serial_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int unsigned ERR_CNT_W = 8;

endpackage

// File: rtl/serial_parity_rx_parity_acc.sv
// 1-bit clocked XOR accumulator with clear, load-init and enable; shared
// between the parity receiver and the matching transmitter.
`timescale 1ns/1ps
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic init,
  input  logic en,
  input  logic din,
  output logic acc
);

  logic acc_q, acc_d;

  // Clear wins over load, load wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr)       acc_d = 1'b0;
    else if (load) acc_d = init;
    else if (en)   acc_d = acc_q ^ din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= 1'b0;
    else        acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver (start/data LSB-first/parity/stop) with a valid/ready
// output holding register. SERIAL_PARITY_RX_ERR_CNT_EN adds a saturating err_cnt.
`timescale 1ns/1ps
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              mismatch_q, mismatch_d;
  logic              acc, acc_load, acc_en, done, ferr_new;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              overrun_q, overrun_d;

  parity_acc u_parity_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (done),
    .load  (acc_load),
    .init  (1'(PARITY_ODD)),
    .en    (acc_en),
    .din   (rx),
    .acc   (acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    mismatch_d = mismatch_q;
    acc_load   = 1'b0;
    acc_en     = 1'b0;
    done       = 1'b0;
    ferr_new   = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d  = DATA;
            cnt_d    = '0;
            acc_load = 1'b1;
          end
        end
        DATA: begin
          // Shift-in at the MSB works for DATA_W=1 where a slice would not.
          shift_d = (shift_q >> 1) | (DATA_W'(rx) << (DATA_W - 1));
          acc_en  = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) state_d = PARITY;
        end
        PARITY: begin
          mismatch_d = acc ^ rx;
          state_d    = STOP;
        end
        STOP: begin
          done     = 1'b1;
          ferr_new = ~rx;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A completing frame loads unless an unaccepted frame is still held.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    overrun_d   = done && out_valid_q && !out_ready;
    if (done && (!out_valid_q || out_ready)) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_q;
      perr_d      = mismatch_q;
      ferr_d      = ferr_new;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      perr_d      = 1'b0;
      ferr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      mismatch_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      mismatch_q  <= mismatch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts every erroneous completed frame, including dropped ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done && (mismatch_q || ferr_new) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_serial_parity_rx.sv
// Directed plus randomized bench for serial_parity_rx (DATA_W=8, even parity);
// err_cnt is checked when SERIAL_PARITY_RX_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_serial_parity_rx;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned PARITY_ODD = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              bit_en = 1'b0;
  logic              rx = 1'b1;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;
  logic              busy;
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic [7:0]        err_cnt;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned exp_err = 0;

  serial_parity_rx #(
    .DATA_W     (DATA_W),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx         (rx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Parity bit a correct transmitter would send for this data word.
  function automatic logic good_parity(input logic [DATA_W-1:0] d);
    int unsigned ones = 0;
    for (int i = 0; i < DATA_W; i++) ones += int'(d[i]);
    return logic'((ones + PARITY_ODD) % 2);
  endfunction

  task automatic send_bit(input logic b, input int unsigned period);
    rx = b;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    for (int i = 1; i < period; i++) tick();
  endtask

  // Returns right after the edge that samples the stop bit.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic pbit, input logic stop,
                            input int unsigned period, input logic ready_at_stop);
    send_bit(1'b0, period);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], period);
    send_bit(pbit, period);
    if (ready_at_stop) out_ready = 1'b1;
    rx = stop;
    bit_en = 1'b1;
    tick();
    bit_en = 1'b0;
    rx = 1'b1;
  endtask

  task automatic note_frame(input logic perr, input logic ferr);
    if ((perr || ferr) && exp_err < 255) exp_err++;
  endtask

  task automatic expect_frame(input string tag, input logic [DATA_W-1:0] d,
                              input logic perr, input logic ferr);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".perr"}, 32'(parity_err), 32'(perr));
    check({tag, ".ferr"}, 32'(frame_err), 32'(ferr));
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
    check({tag, ".err_cnt"}, 32'(err_cnt), exp_err);
`endif
  endtask

  task automatic ack(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".ack_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".ack_flags"}, 32'({parity_err, frame_err}), 32'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic inj, stop;
    int unsigned period;

    // Reset state
    tick();
    tick();
    check("rst.valid", 32'(out_valid), 32'd0);
    check("rst.data", 32'(out_data), 32'd0);
    check("rst.flags", 32'({parity_err, frame_err, overrun}), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // Clean frame, then latency-1 delivery
    send_frame(8'hA5, good_parity(8'hA5), 1'b1, 1, 1'b0);
    note_frame(1'b0, 1'b0);
    expect_frame("a5_ok", 8'hA5, 1'b0, 1'b0);
    check("a5_ok.busy", 32'(busy), 32'd0);
    ack("a5_ok");

    // Wrong parity bit
    send_frame(8'hA5, ~good_parity(8'hA5), 1'b1, 1, 1'b0);
    note_frame(1'b1, 1'b0);
    expect_frame("a5_perr", 8'hA5, 1'b1, 1'b0);
    ack("a5_perr");

    // Stop bit 0: framing error, and that 0 must not restart reception
    send_frame(8'h3C, good_parity(8'h3C), 1'b0, 1, 1'b0);
    note_frame(1'b0, 1'b1);
    expect_frame("3c_ferr", 8'h3C, 1'b0, 1'b1);
    check("3c_ferr.busy", 32'(busy), 32'd0);
    tick();
    tick();
    check("3c_ferr.idle_busy", 32'(busy), 32'd0);
    check("3c_ferr.hold", 32'({out_valid, out_data}), 32'({1'b1, 8'h3C}));
    ack("3c_ferr");

    // Overrun: second frame dropped while first is held
    send_frame(8'h11, good_parity(8'h11), 1'b1, 1, 1'b0);
    note_frame(1'b0, 1'b0);
    expect_frame("ovr_first", 8'h11, 1'b0, 1'b0);
    check("ovr_first.overrun", 32'(overrun), 32'd0);
    tick();
    send_frame(8'h22, good_parity(8'h22), 1'b1, 1, 1'b0);
    note_frame(1'b0, 1'b0);
    check("ovr.pulse", 32'(overrun), 32'd1);
    expect_frame("ovr_kept", 8'h11, 1'b0, 1'b0);
    tick();
    check("ovr.pulse_end", 32'(overrun), 32'd0);
    check("ovr.still_held", 32'(out_data), 32'h11);
    ack("ovr");

    // Handshake in the completion cycle: replace without overrun
    send_frame(8'h55, good_parity(8'h55), 1'b1, 1, 1'b0);
    note_frame(1'b0, 1'b0);
    expect_frame("swap_first", 8'h55, 1'b0, 1'b0);
    tick();
    send_frame(8'h66, good_parity(8'h66), 1'b1, 1, 1'b1);
    out_ready = 1'b0;
    note_frame(1'b0, 1'b0);
    expect_frame("swap_second", 8'h66, 1'b0, 1'b0);
    check("swap.overrun", 32'(overrun), 32'd0);
    ack("swap");

    // Slow strobe, async reset mid-frame with a frame still held
    send_frame(8'h77, good_parity(8'h77), 1'b1, 4, 1'b0);
    note_frame(1'b0, 1'b0);
    expect_frame("pre_rst", 8'h77, 1'b0, 1'b0);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    check("mid.busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst.valid", 32'(out_valid), 32'd0);
    check("mid_rst.data", 32'(out_data), 32'd0);
    check("mid_rst.flags", 32'({parity_err, frame_err, overrun}), 32'd0);
    check("mid_rst.busy", 32'(busy), 32'd0);
    exp_err = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_frame(8'h81, good_parity(8'h81), 1'b1, 4, 1'b0);
    note_frame(1'b0, 1'b0);
    expect_frame("post_rst", 8'h81, 1'b0, 1'b0);
    ack("post_rst");

    // Randomized frames against the parity/framing rules
    for (int n = 0; n < 16; n++) begin
      d = DATA_W'($urandom);
      inj = ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 3) != 0);
      period = $urandom_range(1, 3);
      send_frame(d, good_parity(d) ^ inj, stop, period, 1'b0);
      note_frame(inj, ~stop);
      expect_frame("rand", d, inj, ~stop);
      ack("rand");
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
